// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port round-robin arbiter and IDLE/ACCESS/RESP sequencer for a single-ported data memory
module data_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 65536
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  logic [1:0]        state_q, state_d, gnt_q, gnt_d, done_q, done_d;
  logic              err_q, err_d, busy_q, busy_d, we_q, we_d, rng_q, rng_d, last_q, last_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d, sel_addr;
  logic              pick;
  // last_q = 1 means port 1 was served last, so a tie goes to port 0
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = done_q;
    err_d    = err_q;
    busy_d   = busy_q;
    we_d     = we_q;
    rng_d    = rng_q;
    last_d   = last_q;
    rdata_d  = rdata_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    pick     = req_i[1] & (~req_i[0] | ~last_q);
    sel_addr = pick ? addr1_i : addr0_i;
    case (state_q)
      S_IDLE: if (|req_i) begin
        state_d = S_ACCESS;
        gnt_d   = pick ? 2'b10 : 2'b01;
        busy_d  = 1'b1;
        addr_d  = sel_addr;
        wdata_d = pick ? wdata1_i : wdata0_i;
        we_d    = we_i[pick];
        rng_d   = {1'b0, sel_addr} < DEPTH;
      end
      S_ACCESS: begin
        state_d = S_RESP;
        done_d  = gnt_q;
        err_d   = ~rng_q;
        rdata_d = ~rng_q ? '0 : we_q ? rdata_q : mem_rdata_i;
      end
      S_RESP: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        last_d  = gnt_q[1];
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        we_d    = 1'b0;
        rng_d   = 1'b0;
        last_d  = 1'b1;
        rdata_d = '0;
        wdata_d = '0;
        addr_d  = '0;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      rng_q   <= 1'b0;
      last_q  <= 1'b1;
      rdata_q <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      rng_q   <= rng_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
    end
  end
  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign busy_o      = busy_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_we_o    = (state_q == S_ACCESS) & we_q & rng_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed self-checking bench with a 256-word memory model
module tb_data_mem_arbiter;
  logic        clk, rst_n;
  logic [1:0]  req, we, gnt, done, p;
  logic [15:0] addr0, addr1, mem_addr;
  logic [31:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
  logic        err, busy, mem_we;
  logic        pre_we;
  logic [7:0]  pre_a;
  logic [31:0] pre_d;
  logic [31:0] mem [0:255];
  int          n_vec, n_err;

  data_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_DEPTH(256)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .gnt_o(gnt), .done_o(done), .err_o(err), .rdata_o(rdata), .busy_o(busy),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    else if (pre_we) mem[pre_a] <= pre_d;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_a = a;
    pre_d = d;
    pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; req = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    repeat (2) @(negedge clk);
    preload(8'h00, 32'hA5A5A5A5);
    preload(8'h05, 32'hDEADBEEF);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_err", err, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_maddr", mem_addr, 16'h0);
    chk("rst_mwe", mem_we, 1'b0);
    chk("rst_mwdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    // single load on port 0
    req = 2'b01; we = 2'b00; addr0 = 16'h0005;
    @(negedge clk);
    chk("ld_gnt", gnt, 2'b01);
    chk("ld_busy", busy, 1'b1);
    chk("ld_mwe", mem_we, 1'b0);
    chk("ld_maddr", mem_addr, 16'h0005);
    chk("ld_done_early", done, 2'b00);
    req = 2'b00;
    @(negedge clk);
    chk("ld_gnt2", gnt, 2'b01);
    chk("ld_done", done, 2'b01);
    chk("ld_rdata", rdata, 32'hDEADBEEF);
    chk("ld_err", err, 1'b0);
    chk("ld_mwe2", mem_we, 1'b0);
    @(negedge clk);
    chk("ld_idle_done", done, 2'b00);
    chk("ld_idle_gnt", gnt, 2'b00);
    chk("ld_idle_busy", busy, 1'b0);
    chk("ld_hold", rdata, 32'hDEADBEEF);
    // single store on port 1, then read back through port 0
    req = 2'b10; we = 2'b10; addr1 = 16'h0010; wdata1 = 32'h12345678;
    @(negedge clk);
    chk("st_mwe", mem_we, 1'b1);
    chk("st_maddr", mem_addr, 16'h0010);
    chk("st_mwdata", mem_wdata, 32'h12345678);
    chk("st_gnt", gnt, 2'b10);
    req = 2'b00;
    @(negedge clk);
    chk("st_mwe_off", mem_we, 1'b0);
    chk("st_done", done, 2'b10);
    chk("st_rdata_hold", rdata, 32'hDEADBEEF);
    chk("st_err", err, 1'b0);
    @(negedge clk);
    chk("st_mem", mem[16], 32'h12345678);
    req = 2'b01; we = 2'b00; addr0 = 16'h0010;
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    chk("rb_done", done, 2'b01);
    chk("rb_rdata", rdata, 32'h12345678);
    @(negedge clk);
    // out-of-range store
    req = 2'b01; we = 2'b01; addr0 = 16'h0100; wdata0 = 32'hFFFFFFFF;
    @(negedge clk);
    chk("oor_mwe", mem_we, 1'b0);
    chk("oor_gnt", gnt, 2'b01);
    req = 2'b00;
    @(negedge clk);
    chk("oor_done", done, 2'b01);
    chk("oor_err", err, 1'b1);
    chk("oor_rdata", rdata, 32'h0);
    @(negedge clk);
    chk("oor_err_clr", err, 1'b0);
    chk("oor_mem0", mem[0], 32'hA5A5A5A5);
    // reset in the middle of a port-1 store
    req = 2'b10; we = 2'b10; addr1 = 16'h0020; wdata1 = 32'h00000055;
    @(negedge clk);
    chk("rma_mwe", mem_we, 1'b1);
    chk("rma_gnt", gnt, 2'b10);
    req = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    chk("rma_mwe_async", mem_we, 1'b0);
    chk("rma_gnt_async", gnt, 2'b00);
    chk("rma_busy_async", busy, 1'b0);
    @(negedge clk);
    chk("rma_no_done", done, 2'b00);
    // continuous contention after reset release
    rst_n = 1'b1;
    req = 2'b11; we = 2'b00; addr0 = 16'h0005; addr1 = 16'h0010;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      p = (((k - 1) / 3) % 2 == 1) ? 2'b10 : 2'b01;
      chk("ct_gnt", gnt, (k % 3 == 0) ? 2'b00 : p);
      chk("ct_done", done, (k % 3 == 2) ? p : 2'b00);
      if (k % 3 == 2) chk("ct_rdata", rdata, p[1] ? 32'h12345678 : 32'hDEADBEEF);
    end
    // port 0 drops req during ACCESS
    req = 2'b01; we = 2'b00; addr0 = 16'h0005;
    @(negedge clk);
    chk("drop_gnt", gnt, 2'b01);
    req = 2'b00;
    @(negedge clk);
    chk("drop_done", done, 2'b01);
    chk("drop_rdata", rdata, 32'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("drop_no_gnt", gnt, 2'b00);
      chk("drop_no_done", done, 2'b00);
      chk("drop_idle", busy, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
